// File: rtl/rx_frame_ctrl.sv
// UART-style 8N1 receiver with centre-of-bit sampling and a one-entry output
// holding register that reports overrun and bad-stop-bit framing errors.
module rx_frame_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ready,
  input  logic       clr_overrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [3:0] bit_count
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      shift_q;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic            stop_done;
  logic            stop_good;
  logic            stop_bad;

  assign rx_s      = sync_q[1];
  assign stop_done = (state_q == StStop) && (cnt_q == BitLast);
  assign stop_good = stop_done && rx_s;
  assign stop_bad  = stop_done && !rx_s;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      sync_q    <= 2'b11;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      bit_count <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      frame_err <= stop_bad;

      // A drop in the same cycle as clr_overrun must leave the flag set.
      if (clr_overrun) overrun <= 1'b0;
      if (stop_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          bit_count <= '0;
          if (!rx_s) state_q <= StStart;
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_count <= bit_count + 4'd1;
            if (bit_count == 4'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
